// File: rtl/m_dmem_requester_if.sv
// Pipeline-side request/response and cache-side dmem signals of the data-memory requester.
// The master modport is the requester; the slave modport is the LSU/cache environment.
interface m_dmem_requester_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_timeout;
  logic        o_dmem_ren;
  logic [3:0]  o_dmem_wen;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_data;
  logic [31:0] i_dmem_data;
  logic        i_dmem_stall;

  modport master (
    input  i_req_valid, i_req_we, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
    input  i_dmem_data, i_dmem_stall,
    output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_timeout,
    output o_dmem_ren, o_dmem_wen, o_dmem_addr, o_dmem_data
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
    output i_dmem_data, i_dmem_stall,
    input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_timeout,
    input  o_dmem_ren, o_dmem_wen, o_dmem_addr, o_dmem_data
  );
endinterface

// File: rtl/m_dmem_requester.sv
// Sizes one load/store at a time onto the cache dmem port; hit response 3 cycles after accept.
// Backpressure: ready only in IDLE with the cache not stalled; misses hold the FSM in WAIT.
module m_dmem_requester #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input logic              i_clk,
  input logic              i_rst_n,
  m_dmem_requester_if.master bus
);

  localparam int unsigned CW = $clog2(STALL_TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_CNT  = CW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        signed_q, signed_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic        ren_q, ren_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        req_illegal;
  logic [3:0]  req_mask;
  logic [31:0] req_lane;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  assign bus.o_req_ready = (state_q == IDLE) && !bus.i_dmem_stall;
  assign accept          = bus.i_req_valid && bus.o_req_ready;

  assign req_illegal = (bus.i_req_size == 2'b11)
                    || (bus.i_req_size == 2'b01 && bus.i_req_addr[0])
                    || (bus.i_req_size == 2'b10 && bus.i_req_addr[1:0] != 2'b00);

  always_comb begin
    req_mask = 4'b1111;
    req_lane = bus.i_req_wdata;
    unique case (bus.i_req_size)
      2'b00: begin
        req_mask = 4'b0001 << bus.i_req_addr[1:0];
        req_lane = {4{bus.i_req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask = 4'b0011 << bus.i_req_addr[1:0];
        req_lane = {2{bus.i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfwords are aligned, so the byte-lane shift also selects the correct half.
  assign rd_shift = bus.i_dmem_data >> {lo_q, 3'b000};

  always_comb begin
    load_ext = bus.i_dmem_data;
    unique case (size_q)
      2'b00:   load_ext = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                   : {24'h0, rd_shift[7:0]};
      2'b01:   load_ext = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                   : {16'h0, rd_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      lo_q        <= 2'b00;
      ren_q       <= 1'b0;
      wen_q       <= 4'h0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'h0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      signed_q    <= signed_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !req_illegal) state_d = ISSUE;
      ISSUE:   if (!bus.i_dmem_stall)      state_d = WAIT;
      WAIT:    if (!bus.i_dmem_stall)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    signed_d    = signed_q;
    size_d      = size_q;
    lo_d        = lo_q;
    ren_d       = ren_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    cnt_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = bus.i_req_we;
          signed_d = bus.i_req_signed;
          size_d   = bus.i_req_size;
          lo_d     = bus.i_req_addr[1:0];
          if (req_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = 32'h0;
          end else begin
            ren_d  = !bus.i_req_we;
            wen_d  = bus.i_req_we ? req_mask : 4'h0;
            addr_d = {bus.i_req_addr[31:2], 2'b00};
            data_d = req_lane;
          end
        end
      end
      ISSUE: begin
        if (!bus.i_dmem_stall) begin
          ren_d = 1'b0;
          wen_d = 4'h0;
        end
      end
      WAIT: begin
        if (bus.i_dmem_stall) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (STALL_TIMEOUT != 0 && cnt_d == TO_CNT) timeout_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? 32'h0 : load_ext;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_dmem_ren  = ren_q;
  assign bus.o_dmem_wen  = wen_q;
  assign bus.o_dmem_addr = addr_q;
  assign bus.o_dmem_data = data_q;

endmodule

// File: tb/tb_m_dmem_requester.sv
// Directed bench for m_dmem_requester against a small byte-enabled memory that shows junk while stalled.
module tb_m_dmem_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  m_dmem_requester_if bus ();

  m_dmem_requester #(.STALL_TIMEOUT(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [31:0] mem_rd = 32'h0;

  always @(posedge clk) begin
    if (!bus.i_dmem_stall) begin
      if (bus.o_dmem_ren) mem_rd <= mem[bus.o_dmem_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (bus.o_dmem_wen[b]) mem[bus.o_dmem_addr[11:2]][8*b +: 8] <= bus.o_dmem_data[8*b +: 8];
    end
  end

  assign bus.i_dmem_data = bus.i_dmem_stall ? 32'hBAD0_BAD0 : mem_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd, input int stall_n,
                    input logic exp_err, input logic [3:0] exp_wen, input logic [31:0] exp_data,
                    input logic [31:0] exp_rdata);
    int k;
    int lat;
    logic got_rsp, rsp_err, rdy_at, ren1, any_en, late_en, stable;
    logic [3:0]  wen1;
    logic [31:0] addr_pre, addr1, data1, rdata;
    @(negedge clk);
    bus.i_dmem_stall = 1'b0;
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = we;
    bus.i_req_size   = sz;
    bus.i_req_signed = sg;
    bus.i_req_addr   = a;
    bus.i_req_wdata  = wd;
    k = 0;
    while (!bus.o_req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_accept"}, 32'(bus.o_req_ready), 32'd1);
    addr_pre = bus.o_dmem_addr;
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    ren1 = bus.o_dmem_ren;
    wen1 = bus.o_dmem_wen;
    addr1 = bus.o_dmem_addr;
    data1 = bus.o_dmem_data;
    any_en = 1'b0; late_en = 1'b0; stable = 1'b1; got_rsp = 1'b0;
    rsp_err = 1'b0; rdy_at = 1'b0; rdata = 32'h0; lat = 0;
    for (k = 1; k < 60; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.o_dmem_ren || |bus.o_dmem_wen) begin
        any_en = 1'b1;
        if (k >= 2) late_en = 1'b1;
      end
      if (k >= 2 && bus.o_dmem_addr !== addr1) stable = 1'b0;
      if (bus.o_rsp_valid) begin
        got_rsp = 1'b1;
        lat     = k;
        rsp_err = bus.o_rsp_err;
        rdata   = bus.o_rsp_rdata;
        rdy_at  = bus.o_req_ready;
        break;
      end
      bus.i_dmem_stall = (k >= 2) && (k < 2 + stall_n);
    end
    bus.i_dmem_stall = 1'b0;
    check_val({tag, "_rsp_seen"}, 32'(got_rsp), 32'd1);
    check_val({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check_val({tag, "_rdata"}, rdata, exp_rdata);
    check_val({tag, "_ready_at_rsp"}, 32'(rdy_at), 32'd1);
    if (exp_err) begin
      check_val({tag, "_latency"}, 32'(lat), 32'd1);
      check_val({tag, "_no_enable"}, 32'(any_en), 32'd0);
      check_val({tag, "_addr_untouched"}, addr1, addr_pre);
    end else begin
      check_val({tag, "_latency"}, 32'(lat), 32'(3 + stall_n));
      check_val({tag, "_ren"}, 32'(ren1), 32'(!we));
      check_val({tag, "_wen"}, 32'(wen1), 32'(exp_wen));
      check_val({tag, "_addr"}, addr1, {a[31:2], 2'b00});
      if (we) check_val({tag, "_wdata"}, data1, exp_data);
      check_val({tag, "_enable_dropped"}, 32'(late_en), 32'd0);
      check_val({tag, "_addr_stable"}, 32'(stable), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_seen;
    logic rsp_seen;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_size   = 2'b00;
    bus.i_req_signed = 1'b0;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;
    bus.i_dmem_stall = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_ren", 32'(bus.o_dmem_ren), 32'd0);
    check_val("reset_wen", 32'(bus.o_dmem_wen), 32'd0);
    check_val("reset_addr", bus.o_dmem_addr, 32'h0);
    check_val("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check_val("reset_timeout", 32'(bus.o_timeout), 32'd0);
    check_val("reset_ready", 32'(bus.o_req_ready), 32'd0);
    rst_n = 1'b1;

    // Pending store while the cache stalls out of reset.
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_size  = 2'b10;
    bus.i_req_addr  = 32'h100;
    bus.i_req_wdata = 32'hDEADBEEF;
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("stall_idle_ready", 32'(bus.o_req_ready), 32'd0);
      if (bus.o_dmem_ren || |bus.o_dmem_wen) en_seen = 1'b1;
    end
    check_val("stall_idle_no_enable", 32'(en_seen), 32'd0);
    op("sw_100",  1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);

    op("lb_103",  1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFFFDE);
    op("lbu_103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h000000DE);
    op("lh_100",  1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFBEEF);
    op("lhu_102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0000DEAD);
    op("lw_100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF);

    op("sh_102",  1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
    op("lw_sh",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hABCDBEEF);
    op("sb_101",  1'b1, 2'b00, 1'b0, 32'h101, 32'h00000077, 0, 1'b0, 4'b0010, 32'h77777777, 32'h0);
    op("lw_sb",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hABCD77EF);
    op("lb_101",  1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h00000077);
    op("lb_100",  1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFFFEF);

    op("err_lw_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0);
    op("err_size11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0);
    op("err_lh_101", 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0);
    op("err_sw_101", 1'b1, 2'b10, 1'b0, 32'h101, 32'hFFFFFFFF, 0, 1'b1, 4'h0, 32'h0, 32'h0);

    check_val("timeout_before_miss", 32'(bus.o_timeout), 32'd0);
    op("miss_lw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 20, 1'b0, 4'h0, 32'h0, 32'hABCD77EF);
    op("miss_sw",  1'b1, 2'b10, 1'b0, 32'h104, 32'h5A5A1234, 5, 1'b0, 4'b1111, 32'h5A5A1234, 32'h0);
    op("lh_106",   1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 3, 1'b0, 4'h0, 32'h0, 32'h00005A5A);
    check_val("timeout_after_miss", 32'(bus.o_timeout), 32'd1);

    // Stuck stall: timeout threshold, stickiness, then asynchronous reset mid-WAIT.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("timeout_cleared", 32'(bus.o_timeout), 32'd0);
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = 1'b0;
    bus.i_req_size   = 2'b10;
    bus.i_req_addr   = 32'h100;
    bus.i_req_wdata  = 32'hCAFEF00D;
    bus.i_dmem_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check_val("stuck_ren", 32'(bus.o_dmem_ren), 32'd1);
    @(negedge clk);
    bus.i_dmem_stall = 1'b1;
    repeat (7) @(negedge clk);
    check_val("timeout_after_7", 32'(bus.o_timeout), 32'd0);
    @(negedge clk);
    check_val("timeout_after_8", 32'(bus.o_timeout), 32'd1);
    repeat (5) @(negedge clk);
    check_val("timeout_sticky", 32'(bus.o_timeout), 32'd1);
    check_val("stuck_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    check_val("stuck_addr_held", bus.o_dmem_addr, 32'h100);
    check_val("stuck_data_held", bus.o_dmem_data, 32'hCAFEF00D);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_ren", 32'(bus.o_dmem_ren), 32'd0);
    check_val("arst_wen", 32'(bus.o_dmem_wen), 32'd0);
    check_val("arst_addr", bus.o_dmem_addr, 32'h0);
    check_val("arst_data", bus.o_dmem_data, 32'h0);
    check_val("arst_rsp", {bus.o_rsp_valid, bus.o_rsp_err, 30'h0}, 32'h0);
    check_val("arst_rdata", bus.o_rsp_rdata, 32'h0);
    check_val("arst_timeout", 32'(bus.o_timeout), 32'd0);
    check_val("arst_ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_dmem_stall = 1'b0;
    rsp_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_rsp_valid) rsp_seen = 1'b1;
    end
    check_val("abandoned_no_rsp", 32'(rsp_seen), 32'd0);
    op("lw_recover", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hABCD77EF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
